mux_scan_seq: RTL and testbench
===============================

MUX_SCAN_SEQ -- requirements
Module: mux_scan_seq

Interface
REQ-001: Parameter NCH, default 16, is the number of input channels (2..64).
REQ-002: Parameter DW, default 1, is the data width per channel in bits.
REQ-003: Derived constant SW = ceil(log2(NCH)) is the channel index width.
REQ-004: clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005: rst  input  1  is the reset: synchronous, active-high.
REQ-006: in  input  NCH*DW  carries the channel data; channel k occupies bits [k*DW +: DW].
REQ-007: mode  input  1  selects the operating mode: 0 = manual select, 1 = auto-scan.
REQ-008: sel  input  SW  is the manual channel select, used only when mode=0.
REQ-009: en_mask  input  NCH  is the per-channel scan enable; it is sampled at start.
REQ-010: start  input  1  is a single-cycle pulse that begins a scan when mode=1 and the block is idle.
REQ-011: out_data  output  DW  is the registered selected channel data.
REQ-012: out_ch  output  SW  is the channel index of out_data.
REQ-013: out_valid  output  1  is high when out_data and out_ch are valid.
REQ-014: out_ready  input  1  is the downstream accept signal; a transfer occurs when out_valid and out_ready are both high in the same cycle.
REQ-015: busy  output  1  is high while a scan is in progress.
REQ-016: done  output  1  is a one-cycle pulse when a scan completes.

Function
REQ-017: The FSM SHALL have three states:
  - IDLE
  - SCAN
  - FIN
REQ-018: In IDLE with mode=0, the output register SHALL load in[sel] and sel, and set out_valid=1, on every cycle that is not stalled; latency is 1 cycle.
REQ-019: Stalled SHALL mean out_valid=1 and out_ready=0; while stalled, out_data, out_ch and out_valid SHALL hold unchanged.
REQ-020: In IDLE with mode=1 and no start, out_valid SHALL be 0 once any pending word is accepted.
REQ-021: start in IDLE with mode=1 SHALL:
  - latch en_mask into mask_r;
  - set busy=1 on the next cycle;
  - move the FSM to SCAN, with the pointer at the lowest enabled channel.
REQ-022: In SCAN, each enabled channel SHALL be presented exactly once, in ascending index order, with out_ch equal to that index.
REQ-023: Disabled channels SHALL be skipped with zero idle cycles between presented channels when out_ready is held at 1.
REQ-024: The pointer SHALL advance only on a transfer.
REQ-025: The transfer of the highest enabled channel SHALL move the FSM to FIN.
REQ-026: FIN SHALL last one cycle, with done=1, busy=0 and out_valid=0, and then return to IDLE.
REQ-027: start with mask_r all-zero SHALL go directly to FIN (done pulse two cycles after start) and emit no words.
REQ-028: start while busy SHALL be ignored.
REQ-029: Changes to mode, en_mask or sel during SCAN or FIN SHALL be ignored; mode is re-evaluated only in IDLE.
REQ-030: in SHALL be sampled at the cycle each word is loaded, not at start.
REQ-031: sel values of NCH or greater (non-power-of-two NCH) SHALL produce out_data=0 with out_ch=sel.

Reset
REQ-032: rst=1 SHALL force, on the next rising edge regardless of state (including mid-scan or mid-stall):
  - FSM = IDLE
  - out_data = 0, out_ch = 0
  - out_valid = 0, busy = 0, done = 0
  - mask_r = 0, pointer = 0
REQ-033: No output transfer SHALL be reported in the cycle after reset is released.

Structure
REQ-034: Package mux_scan_pkg SHALL hold:
  - the state encoding (IDLE, SCAN, FIN);
  - the mode constants MODE_MANUAL=0 and MODE_SCAN=1.
REQ-035: Sub-module mux_scan_pick SHALL be combinational and shall:
  - take mask_r and a start index;
  - return the next enabled index at or above that start index;
  - return a none-left flag.
REQ-036: The parameter defaults SHALL remain backward compatible with the existing 16:1, 1-bit mux usage.

Verification (NCH=16, DW=1, in=16'b1010_1100_0110_1001)
REQ-037: Manual mode, out_ready=1, sel swept 0..15 -> one cycle later out_data = in[sel], out_ch = sel (e.g. sel=3 -> 1, sel=4 -> 0).
REQ-038: Scan, en_mask=16'hFFFF, out_ready=1 -> 16 consecutive words with out_ch 0..15 matching the in bits, then a done pulse, with busy high throughout.
REQ-039: Scan, en_mask=16'h8421 -> words only for channels 0, 5, 10, 15, back-to-back, then done.
REQ-040: Scan with out_ready low for 3 cycles on channel 5 -> ch5 held stable for 3 cycles, no channel lost or duplicated.
REQ-041: Scan with en_mask=0 -> no out_valid, done two cycles after start; a second start during an active scan is ignored.
REQ-042: rst asserted mid-scan at channel 7 -> next cycle all outputs are 0 and FSM is IDLE; a new start rescans from channel 0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state encoding and mode constants for the channel mux/scanner
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_pick.sv
// rtl/mux_scan_pick.sv - finds the next enabled channel at or above a start index
module mux_scan_pick
  import mux_scan_pkg::*;
#(
  parameter int NCH = 16,
  parameter int SW  = 4
) (
  input  logic [NCH-1:0] mask,
  input  logic [SW:0]    start_idx,
  output logic [SW-1:0]  idx,
  output logic           none
);

  // Walk from the top down so the lowest qualifying channel is the last one written.
  // start_idx is one bit wider than a channel index so "past the last channel" is representable.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start_idx))) begin
        idx  = SW'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// rtl/mux_scan_seq.sv - NCH:1 registered mux with manual select and masked auto-scan
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int  NCH = 16,
  parameter int  DW  = 1,
  localparam int SW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] in,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [NCH-1:0]    en_mask,
  input  logic              start,
  output logic [DW-1:0]     out_data,
  output logic [SW-1:0]     out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  state_t         state, state_nx;
  logic [NCH-1:0] mask_r, mask_nx;
  logic [SW-1:0]  ptr, ptr_nx;
  logic           primed, primed_nx;
  logic [DW-1:0]  out_data_nx;
  logic [SW-1:0]  out_ch_nx;
  logic           out_valid_nx;

  logic           stalled;
  logic           xfer;
  logic [SW:0]    pick_base;
  logic [SW-1:0]  pick_idx;
  logic           pick_none;
  logic           advance;

  // Out-of-range indices (non-power-of-two NCH) read as zero instead of aliasing.
  function automatic logic [DW-1:0] chan_data(input logic [NCH*DW-1:0] bus,
                                              input logic [SW-1:0]     idx);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx == SW'(k)) d = bus[k*DW +: DW];
    end
    return d;
  endfunction

  assign stalled = out_valid & ~out_ready;
  assign xfer    = out_valid & out_ready;

  // Before the first scan word is loaded (primed=0) search from ptr itself, afterwards from ptr+1.
  assign pick_base = primed ? ({1'b0, ptr} + (SW+1)'(1)) : {1'b0, ptr};

  mux_scan_pick #(
    .NCH (NCH),
    .SW  (SW)
  ) u_pick (
    .mask      (mask_r),
    .start_idx (pick_base),
    .idx       (pick_idx),
    .none      (pick_none)
  );

  assign busy = (state == SCAN);
  assign done = (state == FIN);

  // State and datapath registers; reset wins over everything, including a stalled word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask_r    <= '0;
      ptr       <= '0;
      primed    <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      mask_r    <= mask_nx;
      ptr       <= ptr_nx;
      primed    <= primed_nx;
      out_data  <= out_data_nx;
      out_ch    <= out_ch_nx;
      out_valid <= out_valid_nx;
    end
  end

  // Next-state and output-register load decisions.
  always_comb begin
    state_nx     = state;
    mask_nx      = mask_r;
    ptr_nx       = ptr;
    primed_nx    = primed;
    out_data_nx  = out_data;
    out_ch_nx    = out_ch;
    out_valid_nx = out_valid;
    advance      = 1'b0;

    case (state)
      IDLE: begin
        if (mode == MODE_MANUAL) begin
          if (!stalled) begin
            out_data_nx  = chan_data(in, sel);
            out_ch_nx    = sel;
            out_valid_nx = 1'b1;
          end
        end else begin
          if (xfer) out_valid_nx = 1'b0;
          if (start) begin
            mask_nx   = en_mask;
            ptr_nx    = '0;
            primed_nx = 1'b0;
            state_nx  = SCAN;
          end
        end
      end

      SCAN: begin
        // First word waits only for a leftover manual word to drain; later words need a transfer.
        advance = primed ? xfer : !stalled;
        if (advance) begin
          if (pick_none) begin
            out_valid_nx = 1'b0;
            primed_nx    = 1'b0;
            state_nx     = FIN;
          end else begin
            out_data_nx  = chan_data(in, pick_idx);
            out_ch_nx    = pick_idx;
            out_valid_nx = 1'b1;
            ptr_nx       = pick_idx;
            primed_nx    = 1'b1;
          end
        end
      end

      FIN: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// tb/tb_mux_scan_seq.sv - randomized self-checking bench for mux_scan_seq
module tb_mux_scan_seq;
  import mux_scan_pkg::*;

  localparam int NCH = 16;
  localparam int DW  = 1;
  localparam int SW  = 4;
  localparam logic [15:0] PAT = 16'b1010_1100_0110_1001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NCH*DW-1:0] in;
  logic              mode;
  logic [SW-1:0]     sel;
  logic [NCH-1:0]    en_mask;
  logic              start;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     out_ch;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  mux_scan_seq #(.NCH(NCH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in(in), .mode(mode), .sel(sel), .en_mask(en_mask),
    .start(start), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  // Non-power-of-two, multi-bit instance for the out-of-range select case.
  logic [47:0] in12;
  logic [3:0]  sel12;
  logic [3:0]  od12;
  logic [3:0]  oc12;
  logic        ov12, busy12, done12;

  mux_scan_seq #(.NCH(12), .DW(4)) dut12 (
    .clk(clk), .rst(rst), .in(in12), .mode(1'b0), .sel(sel12), .en_mask(12'h000),
    .start(1'b0), .out_data(od12), .out_ch(oc12), .out_valid(ov12),
    .out_ready(1'b1), .busy(busy12), .done(done12)
  );

  int checks_passed = 0;
  int checks_total  = 0;

  int cap_ch[$];
  int cap_data[$];
  int cap_step[$];
  int exp_ch[$];
  int exp_data[$];
  int done_step, busy_err, hold_err, data_err, extra_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: every enabled channel once, ascending, carrying its bit of data.
  function automatic void build_expect(input logic [15:0] mask, input logic [15:0] data);
    exp_ch.delete();
    exp_data.delete();
    for (int k = 0; k < 16; k++) begin
      if (mask[k]) begin
        exp_ch.push_back(k);
        exp_data.push_back(int'(data[k]));
      end
    end
  endfunction

  function automatic int word_diff(input bit with_data);
    if (cap_ch.size() != exp_ch.size()) return 1;
    foreach (cap_ch[i]) begin
      if (cap_ch[i] != exp_ch[i]) return 1;
      if (with_data && cap_data[i] != exp_data[i]) return 1;
    end
    return 0;
  endfunction

  function automatic int step_gaps();
    int g;
    g = 0;
    for (int i = 1; i < cap_step.size(); i++) begin
      if (cap_step[i] != cap_step[i-1] + 1) g++;
    end
    return g;
  endfunction

  // Runs one scan: pulses start, drives out_ready, records every transfer and anomalies.
  task automatic do_scan(input logic [15:0] mask, input int ready_pct, input int stall_ch,
                         input int stall_len, input int restart_step, input bit vary_in);
    int            stall_left;
    logic          prev_stall;
    logic [SW-1:0] prev_ch;
    logic [DW-1:0] prev_data;
    logic [15:0]   prev_in;
    cap_ch.delete(); cap_data.delete(); cap_step.delete();
    done_step = -1; busy_err = 0; hold_err = 0; data_err = 0; extra_done = 0;
    stall_left = stall_len; prev_stall = 1'b0; prev_ch = '0; prev_data = '0; prev_in = in;
    mode = MODE_SCAN; en_mask = mask; start = 1'b1; out_ready = 1'b1;
    for (int step = 0; step < 300; step++) begin
      if (step == 1) start = 1'b0;
      if (restart_step > 1 && step == restart_step) begin start = 1'b1; en_mask = ~mask; end
      if (restart_step > 1 && step == restart_step + 1) begin
        start = 1'b0; mode = MODE_MANUAL; sel = 4'($urandom_range(15));
      end
      if (restart_step > 1 && step == restart_step + 2) mode = MODE_SCAN;
      if (prev_stall && (out_valid !== 1'b1 || out_ch !== prev_ch || out_data !== prev_data)) hold_err++;
      if (step > 0 && out_valid === 1'b1 && !prev_stall && out_data !== prev_in[out_ch]) data_err++;
      if (done === 1'b1) begin
        if (busy !== 1'b0) busy_err++;
        done_step = step;
        break;
      end
      if (step > 0 && busy !== 1'b1) busy_err++;
      if (out_valid && stall_ch >= 0 && int'(out_ch) == stall_ch && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99) < ready_pct);
      end
      if (out_valid && out_ready) begin
        cap_ch.push_back(int'(out_ch));
        cap_data.push_back(int'(out_data));
        cap_step.push_back(step);
      end
      prev_stall = out_valid && !out_ready;
      prev_ch    = out_ch;
      prev_data  = out_data;
      if (vary_in) in = 16'($urandom);
      prev_in = in;
      tick();
    end
    out_ready = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done === 1'b1 || out_valid === 1'b1 || busy === 1'b1) extra_done++;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid); else checks_passed++;
    checks_total++; if (out_data !== 1'b0) $display("FAIL reset_data: got %0h want 0", out_data); else checks_passed++;
    checks_total++; if (out_ch !== 4'd0) $display("FAIL reset_ch: got %0d want 0", out_ch); else checks_passed++;
    checks_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got %0b%0b want 00", busy, done); else checks_passed++;
    checks_total++; if (ov12 !== 1'b0 || busy12 !== 1'b0 || done12 !== 1'b0) $display("FAIL reset_dut12: got %0b%0b%0b want 000", ov12, busy12, done12); else checks_passed++;
    rst = 1'b0;
    tick();
    checks_total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL release_quiet: got valid=%0b busy=%0b want 0 0", out_valid, busy); else checks_passed++;
  endtask

  task automatic test_manual();
    logic [15:0] pat_v;
    logic [15:0] in_v;
    logic [3:0]  s;
    pat_v = PAT;
    mode = MODE_MANUAL; out_ready = 1'b1; in = pat_v;
    for (int i = 0; i < 16; i++) begin
      sel = 4'(i);
      tick();
      checks_total++;
      if (out_valid !== 1'b1 || out_ch !== 4'(i) || out_data !== pat_v[i])
        $display("FAIL manual_sweep sel=%0d: got v=%0b ch=%0d d=%0b want 1 %0d %0b", i, out_valid, out_ch, out_data, i, pat_v[i]);
      else checks_passed++;
    end
    for (int i = 0; i < 8; i++) begin
      in_v = 16'($urandom); s = 4'($urandom_range(15));
      in = in_v; sel = s;
      tick();
      checks_total++;
      if (out_ch !== s || out_data !== in_v[s]) $display("FAIL manual_random sel=%0d: got ch=%0d d=%0b want %0d %0b", s, out_ch, out_data, s, in_v[s]);
      else checks_passed++;
    end
    in = pat_v; sel = 4'd2;
    tick();
    out_ready = 1'b0; sel = 4'd9; in = ~pat_v;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks_total++;
      if (out_valid !== 1'b1 || out_ch !== 4'd2 || out_data !== pat_v[2]) $display("FAIL manual_stall_hold: got v=%0b ch=%0d d=%0b want 1 2 %0b", out_valid, out_ch, out_data, pat_v[2]);
      else checks_passed++;
    end
    in_v = ~pat_v;
    out_ready = 1'b1;
    tick();
    checks_total++; if (out_ch !== 4'd9 || out_data !== in_v[9]) $display("FAIL manual_release: got ch=%0d d=%0b want 9 %0b", out_ch, out_data, in_v[9]); else checks_passed++;
    mode = MODE_SCAN;
    tick(); tick();
    checks_total++; if (out_valid !== 1'b0) $display("FAIL scan_idle_drain: got %0b want 0", out_valid); else checks_passed++;
  endtask

  task automatic test_scan_full();
    in = PAT;
    do_scan(16'hFFFF, 100, -1, 0, 0, 1'b0);
    build_expect(16'hFFFF, PAT);
    checks_total++; if (word_diff(1'b1) != 0) $display("FAIL full_words: got %0d words want %0d", cap_ch.size(), exp_ch.size()); else checks_passed++;
    checks_total++; if (step_gaps() != 0) $display("FAIL full_back_to_back: got %0d gaps want 0", step_gaps()); else checks_passed++;
    checks_total++; if (cap_step.size() == 0 || done_step != cap_step[cap_step.size()-1] + 1) $display("FAIL full_done_step: got %0d want one after last word", done_step); else checks_passed++;
    checks_total++; if (busy_err != 0 || extra_done != 0) $display("FAIL full_busy: got busy_err=%0d extra=%0d want 0 0", busy_err, extra_done); else checks_passed++;
  endtask

  task automatic test_scan_mask();
    in = PAT;
    do_scan(16'h8421, 100, -1, 0, 0, 1'b0);
    build_expect(16'h8421, PAT);
    checks_total++; if (word_diff(1'b1) != 0) $display("FAIL mask_words: got %0d words want %0d", cap_ch.size(), exp_ch.size()); else checks_passed++;
    checks_total++; if (step_gaps() != 0) $display("FAIL mask_back_to_back: got %0d gaps want 0", step_gaps()); else checks_passed++;
    checks_total++; if (done_step < 0 || busy_err != 0) $display("FAIL mask_done: got done_step=%0d busy_err=%0d want >=0 0", done_step, busy_err); else checks_passed++;
  endtask

  task automatic test_stall();
    in = PAT;
    do_scan(16'hFFFF, 100, 5, 3, 0, 1'b0);
    build_expect(16'hFFFF, PAT);
    checks_total++; if (word_diff(1'b1) != 0) $display("FAIL stall_words: got %0d words want %0d", cap_ch.size(), exp_ch.size()); else checks_passed++;
    checks_total++; if (hold_err != 0) $display("FAIL stall_hold: got %0d changes want 0", hold_err); else checks_passed++;
    checks_total++;
    if (cap_step.size() < 6 || cap_step[5] - cap_step[4] != 4) $display("FAIL stall_len: got size=%0d want ch5 accepted 4 cycles after ch4", cap_step.size());
    else checks_passed++;
  endtask

  task automatic test_zero_mask_restart();
    do_scan(16'h0000, 100, -1, 0, 0, 1'b0);
    checks_total++; if (cap_ch.size() != 0) $display("FAIL zero_words: got %0d want 0", cap_ch.size()); else checks_passed++;
    checks_total++; if (done_step != 2) $display("FAIL zero_done_step: got %0d want 2", done_step); else checks_passed++;
    checks_total++; if (extra_done != 0) $display("FAIL zero_extra: got %0d want 0", extra_done); else checks_passed++;
    in = 16'($urandom);
    do_scan(16'h0FF0, 100, -1, 0, 4, 1'b0);
    build_expect(16'h0FF0, in);
    checks_total++; if (word_diff(1'b1) != 0) $display("FAIL restart_words: got %0d words want %0d", cap_ch.size(), exp_ch.size()); else checks_passed++;
    checks_total++; if (done_step < 0 || extra_done != 0 || busy_err != 0) $display("FAIL restart_single_done: got done=%0d extra=%0d busy_err=%0d want >=0 0 0", done_step, extra_done, busy_err); else checks_passed++;
  endtask

  task automatic test_reset_mid_scan();
    bit seen;
    in = PAT; mode = MODE_SCAN; en_mask = '1; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid === 1'b1 && out_ch === 4'd7) begin seen = 1'b1; break; end
      tick();
    end
    checks_total++; if (!seen) $display("FAIL reach_ch7: got timeout want ch7 presented"); else checks_passed++;
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks_total++;
    if (out_valid !== 1'b0 || out_data !== 1'b0 || out_ch !== 4'd0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL midscan_reset: got v=%0b d=%0b ch=%0d busy=%0b done=%0b want all 0", out_valid, out_data, out_ch, busy, done);
    else checks_passed++;
    rst = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks_total++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL midscan_idle: got busy=%0b v=%0b want 0 0", busy, out_valid); else checks_passed++;
    do_scan(16'hFFFF, 100, -1, 0, 0, 1'b0);
    build_expect(16'hFFFF, PAT);
    checks_total++; if (cap_ch.size() == 0 || cap_ch[0] != 0 || word_diff(1'b1) != 0) $display("FAIL rescan_from_0: got %0d words want 16 starting at 0", cap_ch.size()); else checks_passed++;
  endtask

  task automatic test_random();
    logic [15:0] m;
    for (int it = 0; it < 6; it++) begin
      m = 16'($urandom);
      in = 16'($urandom);
      do_scan(m, 60, -1, 0, 0, 1'b1);
      build_expect(m, 16'h0000);
      checks_total++; if (word_diff(1'b0) != 0) $display("FAIL rand_channels mask=%04h: got %0d words want %0d", m, cap_ch.size(), exp_ch.size()); else checks_passed++;
      checks_total++; if (data_err != 0) $display("FAIL rand_data mask=%04h: got %0d bad words want 0", m, data_err); else checks_passed++;
      checks_total++; if (hold_err != 0) $display("FAIL rand_hold mask=%04h: got %0d changes want 0", m, hold_err); else checks_passed++;
      checks_total++; if (done_step < 0 || busy_err != 0 || extra_done != 0) $display("FAIL rand_done mask=%04h: got done=%0d busy_err=%0d extra=%0d want >=0 0 0", m, done_step, busy_err, extra_done); else checks_passed++;
    end
  endtask

  task automatic test_sel_range();
    int          svals[4];
    logic [3:0]  exp_d;
    svals[0] = 3; svals[1] = 11; svals[2] = 12; svals[3] = 15;
    in12 = {16'($urandom), 32'($urandom)};
    for (int i = 0; i < 4; i++) begin
      sel12 = 4'(svals[i]);
      exp_d = (svals[i] < 12) ? in12[svals[i]*4 +: 4] : 4'h0;
      tick();
      checks_total++;
      if (od12 !== exp_d || oc12 !== 4'(svals[i]) || ov12 !== 1'b1)
        $display("FAIL sel_range sel=%0d: got d=%0h ch=%0d v=%0b want %0h %0d 1", svals[i], od12, oc12, ov12, exp_d, svals[i]);
      else checks_passed++;
    end
  endtask

  initial begin
    rst = 1'b1; in = '0; mode = MODE_SCAN; sel = '0; en_mask = '0; start = 1'b0; out_ready = 1'b1;
    in12 = '0; sel12 = '0;
    test_reset();
    test_manual();
    test_scan_full();
    test_scan_mask();
    test_stall();
    test_zero_mask_restart();
    test_reset_mid_scan();
    test_random();
    test_sel_range();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
